serial_ripple_subtractor: RTL and testbench
===========================================

Name: serial_ripple_subtractor

Overview:
- Bit-serial, multi-cycle subtractor computing diff = a - b - bin.
- Resolves one bit per clock with a ripple borrow held in a flop, LSB first.
- Companion to the combinational ripple-carry adder. Intended for area-constrained datapaths and for checking adder results (a + b - b == a).
- Start/done handshake; the result is held until the next operation.

Parameters:
- WIDTH, 4, operand and result width in bits (legal 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new subtraction; honoured only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while the operation is in progress (state RUN).
- done  output  1  single-cycle pulse; diff and borrow are valid and newly updated.
- diff  output  WIDTH  registered difference; holds the last result.
- borrow  output  1  registered borrow-out of the MSB; holds the last result.

Behaviour:
- Reset (async assert, sync release) clears state to IDLE and all outputs to 0: busy=0, done=0, diff=0, borrow=0. Internal operand, index and borrow registers also clear to 0.
- IDLE:
  - start=1 at an edge latches a, b and bin into internal registers, sets idx=0, and loads the borrow flop with bin.
  - Moves to RUN; busy=1 from that edge.
- RUN, one bit per edge for idx = 0 .. WIDTH-1:
  - d = a[idx] ^ b[idx] ^ br
  - br_next = (~a[idx] & b[idx]) | (~(a[idx] ^ b[idx]) & br)
  - d is written into an internal shadow register.
- Result commit:
  - On the edge processing idx = WIDTH-1, the full shadow value is copied to diff and br_next to borrow in the same edge.
  - State moves to DONE; busy=0, done=1.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally; done returns to 0.
- Latency: start accepted at edge E0 gives done high between edges E(WIDTH) and E(WIDTH+1). For WIDTH=4, done is visible after the 4th edge following acceptance. Throughput is one operation per WIDTH+2 cycles.
- Output update: diff and borrow change only on the commit edge, never mid-operation. The previous result stays stable while busy=1.
- Ignored start: start while busy=1 or while in DONE is ignored, with no latching, no restart and no error. An operation can begin only from IDLE; start held high continuously re-triggers on the first IDLE edge.
- Operand changes: changes on a, b or bin after the accepting edge have no effect on the operation in progress.
- Arithmetic is modulo 2^WIDTH; borrow=1 iff the unsigned a < b + bin.
- Reset mid-RUN aborts the operation immediately. Outputs return to 0 and no done pulse is produced.
- State encoding is implementer's choice. Unused encodings must recover to IDLE.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- When defined:
  - Extra output port ovf (1 bit) reports two's-complement signed overflow of a - b - bin.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using latched operands.
  - ovf is committed on the same edge as diff, holds until the next commit, and resets to 0.
- When undefined: no ovf port and no related logic; the rest of the behaviour is identical.

Test Plan:
- WIDTH=4, reset, then start with a=5, b=3, bin=0 -> busy for 4 cycles; done pulse with diff=2, borrow=0.
- a=3, b=5, bin=0 -> diff=14 (0xE), borrow=1. Then a=0, b=0, bin=1 -> diff=15, borrow=1.
- Hold start=1 and change a/b while busy -> in-flight result unaffected, no restart; next operation begins on the cycle after done, using the a/b values sampled then.
- Assert rst two edges into RUN (a=9, b=2) -> diff=0, borrow=0, busy=0 immediately; no done pulse. After release, a=9, b=2 -> diff=7, borrow=0.
- Exhaustive sweep of all 512 (a, b, bin) combinations against a - b - bin reference model -> every diff/borrow matches; done width is exactly 1 cycle; diff stable while busy.
- SUB_OVERFLOW_EN defined: a=8, b=1, bin=0 -> diff=7, ovf=1. a=7, b=1 -> diff=6, ovf=0. a=7, b=15 -> diff=8, ovf=1.

Source files
------------

// File: rtl/serial_ripple_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_ripple_subtractor_if
//   Handshake and operand/result bundle for serial_ripple_subtractor.
//   Parameter WIDTH : operand/result width (2..32).
//   Signals:
//     start  : request a new subtraction (master -> slave)
//     a, b   : minuend / subtrahend      (master -> slave)
//     bin    : borrow-in                 (master -> slave)
//     busy   : operation in progress     (slave -> master)
//     done   : one-cycle result-valid    (slave -> master)
//     diff   : registered difference     (slave -> master)
//     borrow : registered borrow-out     (slave -> master)
//     ovf    : signed overflow, only when SUB_OVERFLOW_EN is defined
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface serial_ripple_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow
`ifdef SUB_OVERFLOW_EN
    , ovf
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow
`ifdef SUB_OVERFLOW_EN
    , ovf
`endif
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// ---------------------------------------------------------------------------
// serial_ripple_subtractor
//   Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per
//   clock, LSB first, ripple borrow held in a flop. Start/done handshake;
//   diff/borrow update only on the commit edge and hold until the next one.
//
//   Parameter WIDTH : operand/result width (2..32), default 4.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous, active-high reset
//     bus : serial_ripple_subtractor_if.slave (start, a, b, bin in;
//           busy, done, diff, borrow [, ovf] out)
//
//   Optional macro SUB_OVERFLOW_EN adds bus.ovf, the two's-complement
//   signed overflow of a - b - bin, committed together with diff.
//
//   Timing: start accepted at edge E0 -> busy from E0, bits processed at
//   E1..E(WIDTH), done high between E(WIDTH) and E(WIDTH+1).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_ripple_subtractor_if.slave   bus
);

  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MSB  = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Single-bit full-subtractor slice on the current index.
  logic abit, bbit, dbit, br_next, last_bit;

  assign abit     = a_q[idx_q];
  assign bbit     = b_q[idx_q];
  assign dbit     = abit ^ bbit ^ br_q;
  assign br_next  = (~abit & bbit) | (~(abit ^ bbit) & br_q);
  assign last_bit = (idx_q == IDXW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    br_d     = br_q;
    borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          br_d     = bus.bin;
          idx_d    = '0;
          shadow_d = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        shadow_d[idx_q] = dbit;
        br_d            = br_next;
        if (last_bit) begin
          // Commit uses the shadow value including the bit resolved this edge.
          diff_d   = shadow_d;
          borrow_d = br_next;
`ifdef SUB_OVERFLOW_EN
          ovf_d    = (a_q[MSB] != b_q[MSB]) && (shadow_d[MSB] != a_q[MSB]);
`endif
          idx_d    = '0;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_ripple_subtractor
//   Testbench for serial_ripple_subtractor (WIDTH=4). Expected results are
//   queued when an operation is launched and popped when done is seen.
//   Covers bus.ovf when SUB_OVERFLOW_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_ripple_subtractor;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: wide arithmetic subtraction, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin);
    exp_t       e;
    logic [W:0] full;
    int         sa, sb, sr;
    full     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff   = full[W-1:0];
    e.borrow = full[W];
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    sr = sa - sb - int'(bin);
    e.ovf = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    return e;
  endfunction

  // Drive start for one edge; returns on the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input exp_t e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; cyc counts edges after acceptance.
  task automatic wait_done(output int cyc, output bit stable);
    logic [W-1:0] d0;
    logic         b0;
    d0     = bus.diff;
    b0     = bus.borrow;
    stable = 1'b1;
    cyc    = 0;
    while (bus.done !== 1'b1 && cyc < int'(W) + 20) begin
      if (bus.diff !== d0 || bus.borrow !== b0) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.borrow} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/borrow=%b required 000",
               {bus.busy, bus.done, bus.borrow});
    end
    n_checks++;
    if (bus.diff !== '0) begin
      n_fail++;
      $display("FAIL reset_diff: got %0d required 0", bus.diff);
    end
`ifdef SUB_OVERFLOW_EN
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b required 0", bus.ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    vec_t tbl[3];
    exp_t e;
    int   cyc;
    bit   stable;
    tbl[0] = '{a: 4'd5, b: 4'd3, bin: 1'b0, diff: 4'd2,  borrow: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 4'd3, b: 4'd5, bin: 1'b0, diff: 4'd14, borrow: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 4'd0, b: 4'd0, bin: 1'b1, diff: 4'd15, borrow: 1'b1, ovf: 1'b0};
    for (int k = 0; k < 3; k++) begin
      launch(tbl[k].a, tbl[k].b, tbl[k].bin, '{tbl[k].diff, tbl[k].borrow, tbl[k].ovf});
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_busy[%0d]: got %b required 1", k, bus.busy);
      end
      wait_done(cyc, stable);
      n_checks++;
      if (cyc != int'(W)) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d required %0d", k, cyc, W);
      end
      n_checks++;
      if (!stable) begin
        n_fail++;
        $display("FAIL basic_stable[%0d]: got changed required held", k);
      end
      n_checks++;
      if (sb_q.size() != 1) begin
        n_fail++;
        $display("FAIL basic_sb[%0d]: got depth %0d required 1", k, sb_q.size());
      end
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      n_checks++;
      if (bus.diff !== e.diff) begin
        n_fail++;
        $display("FAIL basic_diff[%0d]: got %0d required %0d", k, bus.diff, e.diff);
      end
      n_checks++;
      if (bus.borrow !== e.borrow) begin
        n_fail++;
        $display("FAIL basic_borrow[%0d]: got %b required %b", k, bus.borrow, e.borrow);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_done_width[%0d]: done/busy=%b%b required 00", k, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_hold_start();
    exp_t e;
    int   cyc;
    bit   stable;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd5; bus.b = 4'd3; bus.bin = 1'b0;
    sb_q.push_back('{diff: 4'd2, borrow: 1'b0, ovf: 1'b0});
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_busy: got %b required 1", bus.busy);
    end
    // Operands change under a held start while the operation is in flight.
    bus.a = 4'd1; bus.b = 4'd2; bus.bin = 1'b1;
    wait_done(cyc, stable);
    n_checks++;
    if (cyc != int'(W)) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d required %0d", cyc, W);
    end
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    n_checks++;
    if (bus.diff !== e.diff || bus.borrow !== e.borrow) begin
      n_fail++;
      $display("FAIL hold_result: got %0d/%b required %0d/%b", bus.diff, bus.borrow, e.diff, e.borrow);
    end
    bus.a = 4'd9; bus.b = 4'd6;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_restart_in_done: busy/done=%b%b required 00", bus.busy, bus.done);
    end
    bus.a = 4'd12; bus.b = 4'd4; bus.bin = 1'b0;
    sb_q.push_back(model(4'd12, 4'd4, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_retrigger: got busy %b required 1", bus.busy);
    end
    wait_done(cyc, stable);
    n_checks++;
    if (cyc != int'(W) || !stable) begin
      n_fail++;
      $display("FAIL hold2_timing: got latency %0d stable %b required %0d 1", cyc, stable, W);
    end
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    n_checks++;
    if (bus.diff !== e.diff || bus.borrow !== e.borrow) begin
      n_fail++;
      $display("FAIL hold2_result: got %0d/%b required %0d/%b", bus.diff, bus.borrow, e.diff, e.borrow);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   cyc;
    bit   stable;
    bit   saw_done;
    launch(4'd9, 4'd2, 1'b0, model(4'd9, 4'd2, 1'b0));
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags: busy/done=%b%b required 00", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.diff !== '0 || bus.borrow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %0d/%b required 0/0", bus.diff, bus.borrow);
    end
    sb_q.delete();
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: got activity after abort required none");
    end
    launch(4'd9, 4'd2, 1'b0, '{diff: 4'd7, borrow: 1'b0, ovf: 1'b0});
    wait_done(cyc, stable);
    n_checks++;
    if (cyc != int'(W)) begin
      n_fail++;
      $display("FAIL abort_recover_latency: got %0d required %0d", cyc, W);
    end
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    n_checks++;
    if (bus.diff !== e.diff || bus.borrow !== e.borrow) begin
      n_fail++;
      $display("FAIL abort_recover_result: got %0d/%b required %0d/%b", bus.diff, bus.borrow, e.diff, e.borrow);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    exp_t       e;
    int         cyc;
    bit         stable;
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      launch(v[3:0], v[7:4], v[8], model(v[3:0], v[7:4], v[8]));
      wait_done(cyc, stable);
      n_checks++;
      if (cyc != int'(W) || !stable) begin
        n_fail++;
        $display("FAIL sweep_timing a=%0d b=%0d bin=%b: got latency %0d stable %b required %0d 1",
                 v[3:0], v[7:4], v[8], cyc, stable, W);
      end
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      n_checks++;
      if (bus.diff !== e.diff || bus.borrow !== e.borrow) begin
        n_fail++;
        $display("FAIL sweep_result a=%0d b=%0d bin=%b: got %0d/%b required %0d/%b",
                 v[3:0], v[7:4], v[8], bus.diff, bus.borrow, e.diff, e.borrow);
      end
`ifdef SUB_OVERFLOW_EN
      n_checks++;
      if (bus.ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL sweep_ovf a=%0d b=%0d bin=%b: got %b required %b",
                 v[3:0], v[7:4], v[8], bus.ovf, e.ovf);
      end
`endif
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_done_width a=%0d b=%0d: got done %b required 0", v[3:0], v[7:4], bus.done);
      end
    end
  endtask

`ifdef SUB_OVERFLOW_EN
  task automatic test_ovf();
    vec_t tbl[3];
    exp_t e;
    int   cyc;
    bit   stable;
    tbl[0] = '{a: 4'd8, b: 4'd1,  bin: 1'b0, diff: 4'd7, borrow: 1'b0, ovf: 1'b1};
    tbl[1] = '{a: 4'd7, b: 4'd1,  bin: 1'b0, diff: 4'd6, borrow: 1'b0, ovf: 1'b0};
    tbl[2] = '{a: 4'd7, b: 4'd15, bin: 1'b0, diff: 4'd8, borrow: 1'b1, ovf: 1'b1};
    for (int k = 0; k < 3; k++) begin
      launch(tbl[k].a, tbl[k].b, tbl[k].bin, '{tbl[k].diff, tbl[k].borrow, tbl[k].ovf});
      wait_done(cyc, stable);
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      n_checks++;
      if (bus.diff !== e.diff || bus.borrow !== e.borrow) begin
        n_fail++;
        $display("FAIL ovf_diff[%0d]: got %0d/%b required %0d/%b", k, bus.diff, bus.borrow, e.diff, e.borrow);
      end
      n_checks++;
      if (bus.ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL ovf_flag[%0d]: got %b required %b", k, bus.ovf, e.ovf);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold_start();
    test_reset_mid_run();
    test_exhaustive();
`ifdef SUB_OVERFLOW_EN
    test_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
